eth_rx_crc_checker: RTL and testbench

- Parametrised successor to the byte-serial receiver CRC calculator. Computes the Ethernet CRC-32 over a whole frame, including the FCS, delivered DATA_BYTES per beat.
- Checks the CRC residue and the frame length, then reports a one-cycle verdict.
- Sits in the ethernet receiver after preamble/SFD stripping, ahead of the ARP/IP parsers.

---
 rtl/eth_rx_crc_checker.sv | 236 +++++++++++++++++++++++
 tb/tb_eth_rx_crc_checker.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_crc_checker.sv
// eth_rx_crc_checker
// Receive-side Ethernet CRC-32 and frame-length checker. Frame bytes arrive
// DATA_BYTES per beat, after preamble/SFD stripping, with the FCS included.
// Each beat is folded into a reflected CRC-32 register in a single cycle.
// The checker then reports a registered one-cycle verdict: CRC residue
// match, length error, or abort.
//
// Optional build macro: ETH_CRC_STATS_EN
//   defined     -> saturating 16-bit good/bad frame counters on o_good_cnt/o_bad_cnt
//   not defined -> o_good_cnt/o_bad_cnt tied to 0, no counter logic
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no frame open; beats without i_sof are dropped
// ST_ACTIVE | frame open; valid beats are folded and counted
// ST_DONE   | verdict cycle after i_last; i_sof here starts the next frame

module eth_rx_crc_checker #(
   parameter int DATA_BYTES    = 1,
   parameter int MIN_FRAME_LEN = 64,
   parameter int MAX_FRAME_LEN = 1518,
   parameter int LEN_W         = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_sof,
   input  logic                    i_valid,
   input  logic [8*DATA_BYTES-1:0] i_data,
   input  logic [DATA_BYTES-1:0]   i_keep,
   input  logic                    i_last,
   output logic [31:0]             o_crc,
   output logic                    o_done,
   output logic                    o_crc_ok,
   output logic                    o_len_err,
   output logic                    o_abort,
   output logic [LEN_W-1:0]        o_frame_len,
   output logic [15:0]             o_good_cnt,
   output logic [15:0]             o_bad_cnt
);

   localparam int CNT_W = $clog2(DATA_BYTES + 1);

   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME_LEN);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME_LEN);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Number of leading ones in the keep vector; bits past the first zero
   // never count, so a malformed keep cannot pull in stray bytes.
   function automatic logic [CNT_W-1:0] keep_count(input logic [DATA_BYTES-1:0] keep);
      logic [CNT_W-1:0] n;
      logic             run;
      n   = '0;
      run = 1'b1;
      for (int b = 0; b < DATA_BYTES; b++) begin
         run = run & keep[b];
         if (run) begin
            n = n + CNT_W'(1);
         end
      end
      return n;
   endfunction

   // Bit-serial reflected CRC unrolled across the enabled bytes of one beat.
   function automatic logic [31:0] crc_fold(input logic [31:0]             crc_in,
                                            input logic [8*DATA_BYTES-1:0] data,
                                            input logic [CNT_W-1:0]        nbytes);
      logic [31:0] c;
      logic        fb;
      c = crc_in;
      for (int b = 0; b < DATA_BYTES; b++) begin
         if (b < int'(nbytes)) begin
            for (int k = 0; k < 8; k++) begin
               fb = c[0] ^ data[8*b+k];
               c  = c >> 1;
               if (fb) begin
                  c = c ^ CRC_POLY;
               end
            end
         end
      end
      return c;
   endfunction

   // Byte counter add that sticks at all-ones instead of wrapping, so a
   // runaway frame is still flagged as oversize.
   function automatic logic [LEN_W-1:0] len_add(input logic [LEN_W-1:0] base,
                                                input logic [CNT_W-1:0] n);
      logic [LEN_W:0] sum;
      sum = {1'b0, base} + (LEN_W+1)'(n);
      return sum[LEN_W] ? {LEN_W{1'b1}} : sum[LEN_W-1:0];
   endfunction

   state_t             state_q, state_d;
   logic [31:0]        crc_q, crc_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               done_d, ok_d, lerr_d, abort_d;
   logic [LEN_W-1:0]   flen_d;

   logic [CNT_W-1:0]   beat_bytes;
   logic [31:0]        base_crc;
   logic [LEN_W-1:0]   base_len;
   logic [31:0]        crc_beat;
   logic [LEN_W-1:0]   len_beat;
   logic               end_ok;
   logic               end_lerr;

   // Beat datapath: a new frame folds its first beat from the init value,
   // otherwise the running register and count carry on.
   always_comb begin
      beat_bytes = i_valid ? keep_count(i_keep) : '0;
      base_crc   = i_sof ? CRC_INIT : crc_q;
      base_len   = i_sof ? '0 : len_q;
      crc_beat   = crc_fold(base_crc, i_data, beat_bytes);
      len_beat   = len_add(base_len, beat_bytes);
      end_ok     = (crc_beat == CRC_RESIDUE);
      end_lerr   = (len_beat < LEN_MIN) || (len_beat > LEN_MAX);
   end

   // Next-state and verdict decode.
   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      len_d   = len_q;
      done_d  = 1'b0;
      ok_d    = 1'b0;
      lerr_d  = 1'b0;
      abort_d = 1'b0;
      flen_d  = o_frame_len;

      case (state_q)
         ST_ACTIVE: begin
            crc_d = crc_beat;
            len_d = len_beat;
            if (i_sof) begin
               // The interrupted frame is reported; a one-beat frame that
               // coincides with the abort loses its own verdict.
               done_d  = 1'b1;
               abort_d = 1'b1;
               flen_d  = len_q;
               state_d = (i_valid && i_last) ? ST_IDLE : ST_ACTIVE;
            end else if (i_valid && i_last) begin
               done_d  = 1'b1;
               ok_d    = end_ok;
               lerr_d  = end_lerr;
               flen_d  = len_beat;
               state_d = ST_DONE;
            end
         end

         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (i_sof) begin
               crc_d = crc_beat;
               len_d = len_beat;
               if (i_valid && i_last) begin
                  done_d  = 1'b1;
                  ok_d    = end_ok;
                  lerr_d  = end_lerr;
                  flen_d  = len_beat;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ACTIVE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, CRC/count registers and the registered verdict outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_IDLE;
         crc_q       <= CRC_INIT;
         len_q       <= '0;
         o_done      <= 1'b0;
         o_crc_ok    <= 1'b0;
         o_len_err   <= 1'b0;
         o_abort     <= 1'b0;
         o_frame_len <= '0;
      end else begin
         state_q     <= state_d;
         crc_q       <= crc_d;
         len_q       <= len_d;
         o_done      <= done_d;
         o_crc_ok    <= ok_d;
         o_len_err   <= lerr_d;
         o_abort     <= abort_d;
         o_frame_len <= flen_d;
      end
   end

   assign o_crc = crc_q;

`ifdef ETH_CRC_STATS_EN
   logic [15:0] good_q;
   logic [15:0] bad_q;

   // Count each verdict as good or bad; counters stick at all-ones.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         good_q <= '0;
         bad_q  <= '0;
      end else if (o_done) begin
         if (o_crc_ok && !o_len_err && !o_abort) begin
            if (good_q != 16'hFFFF) begin
               good_q <= good_q + 16'd1;
            end
         end else begin
            if (bad_q != 16'hFFFF) begin
               bad_q <= bad_q + 16'd1;
            end
         end
      end
   end

   assign o_good_cnt = good_q;
   assign o_bad_cnt  = bad_q;
`else
   assign o_good_cnt = '0;
   assign o_bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_crc_checker.sv
// Directed testbench for eth_rx_crc_checker, built with DATA_BYTES=8.
// Narrower bus widths are exercised by sending 1 or 4 bytes per beat.
module tb_eth_rx_crc_checker;

   logic        clk;
   logic        rst_n;
   logic        sof;
   logic        valid;
   logic [63:0] data;
   logic [7:0]  keep;
   logic        last;
   logic [31:0] crc;
   logic        done;
   logic        crc_ok;
   logic        len_err;
   logic        abort;
   logic [15:0] frame_len;
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int exp_good = 0;
   int exp_bad = 0;

`ifdef ETH_CRC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic [7:0] frm [0:1599];

   eth_rx_crc_checker #(
      .DATA_BYTES(8),
      .MIN_FRAME_LEN(64),
      .MAX_FRAME_LEN(1518),
      .LEN_W(16)
   ) dut (
      .i_clk(clk),
      .i_reset_n(rst_n),
      .i_sof(sof),
      .i_valid(valid),
      .i_data(data),
      .i_keep(keep),
      .i_last(last),
      .o_crc(crc),
      .o_done(done),
      .o_crc_ok(crc_ok),
      .o_len_err(len_err),
      .o_abort(abort),
      .o_frame_len(frame_len),
      .o_good_cnt(good_cnt),
      .o_bad_cnt(bad_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic s, input logic v, input logic l,
                        input logic [63:0] d, input logic [7:0] k);
      @(negedge clk);
      sof = s; valid = v; last = l; data = d; keep = k;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; sof = 1'b0; valid = 1'b0; last = 1'b0; data = '0; keep = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Sends frm[start +: n] in beats of up to bpb bytes.
   task automatic send_bytes(input int start, input int n, input bit with_sof,
                             input bit with_last, input int bpb, input bit junk_keep);
      int pos, rem, k;
      bit first;
      logic [63:0] d;
      logic [7:0] kp;
      logic l;
      pos = start; rem = n; first = 1'b1;
      while (rem > 0) begin
         k = (rem < bpb) ? rem : bpb;
         d = '0; kp = '0;
         for (int j = 0; j < k; j++) begin
            d[8*j +: 8] = frm[pos+j];
            kp[j] = 1'b1;
         end
         l = with_last && (rem == k);
         if (l && junk_keep && k < 7) kp[7] = 1'b1;
         drive(first && with_sof, 1'b1, l, d, kp);
         first = 1'b0;
         pos += k;
         rem -= k;
      end
   endtask

   function automatic logic [31:0] crc_ref(input int n);
      logic [31:0] c;
      logic fb;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ frm[i][b];
            c = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      return c;
   endfunction

   task automatic append_fcs(input int n);
      logic [31:0] f;
      f = ~crc_ref(n);
      frm[n] = f[7:0]; frm[n+1] = f[15:8]; frm[n+2] = f[23:16]; frm[n+3] = f[31:24];
   endtask

   task automatic build_arp();
      for (int i = 0; i < 60; i++) frm[i] = 8'h00;
      for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
      frm[6] = 8'h00; frm[7] = 8'h11; frm[8] = 8'h22;
      frm[9] = 8'h33; frm[10] = 8'h44; frm[11] = 8'h55;
      frm[12] = 8'h08; frm[13] = 8'h06;
      frm[14] = 8'h00; frm[15] = 8'h01; frm[16] = 8'h08; frm[17] = 8'h00;
      frm[18] = 8'h06; frm[19] = 8'h04; frm[20] = 8'h00; frm[21] = 8'h01;
      for (int i = 0; i < 6; i++) frm[22+i] = frm[6+i];
      frm[28] = 8'hC0; frm[29] = 8'hA8; frm[30] = 8'h00; frm[31] = 8'h01;
      frm[38] = 8'hC0; frm[39] = 8'hA8; frm[40] = 8'h00; frm[41] = 8'h02;
      append_fcs(60);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sof = 1'b0; valid = 1'b0; last = 1'b0; data = '0; keep = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (crc !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rst_crc: got %h want ffffffff", crc); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
      n_cmp++; if (crc_ok !== 1'b0) begin n_err++; $display("FAIL rst_crc_ok: got %b want 0", crc_ok); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL rst_len_err: got %b want 0", len_err); end
      n_cmp++; if (abort !== 1'b0) begin n_err++; $display("FAIL rst_abort: got %b want 0", abort); end
      n_cmp++; if (frame_len !== 16'd0) begin n_err++; $display("FAIL rst_frame_len: got %0d want 0", frame_len); end
      n_cmp++; if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", good_cnt, bad_cnt); end
      @(negedge clk); rst_n = 1'b1;
      // a beat without i_sof in IDLE must be ignored
      drive(1'b0, 1'b1, 1'b1, 64'h0123456789ABCDEF, 8'hFF);
      idle();
      n_cmp++; if (crc !== 32'hFFFFFFFF) begin n_err++; $display("FAIL idle_ignore_crc: got %h want ffffffff", crc); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL idle_ignore_done: got %b want 0", done); end
   endtask

   task automatic test_check_value();
      string s;
      s = "123456789";
      for (int i = 0; i < 9; i++) frm[i] = s[i];
      send_bytes(0, 9, 1'b1, 1'b0, 1, 1'b0);
      idle();
      n_cmp++; if ((crc ^ 32'hFFFFFFFF) !== 32'hCBF43926) begin n_err++; $display("FAIL check_value: got %h want cbf43926", crc ^ 32'hFFFFFFFF); end
      do_reset();
   endtask

   task automatic test_good_frame();
      build_arp();
      send_bytes(0, 64, 1'b1, 1'b1, 4, 1'b0);
      idle();
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL good_done: got %b want 1", done); end
      n_cmp++; if (crc_ok !== 1'b1) begin n_err++; $display("FAIL good_crc_ok: got %b want 1", crc_ok); end
      n_cmp++; if (len_err !== 1'b0 || abort !== 1'b0) begin n_err++; $display("FAIL good_flags: got len_err=%b abort=%b want 0/0", len_err, abort); end
      n_cmp++; if (frame_len !== 16'd64) begin n_err++; $display("FAIL good_len: got %0d want 64", frame_len); end
      n_cmp++; if (crc !== 32'hDEBB20E3) begin n_err++; $display("FAIL good_residue: got %h want debb20e3", crc); end
      exp_good++;
      idle();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL good_pulse: got %b want 0", done); end
      n_cmp++; if (crc !== 32'hDEBB20E3) begin n_err++; $display("FAIL good_crc_hold: got %h want debb20e3", crc); end
      n_cmp++; if (good_cnt !== (STATS ? 16'(exp_good) : 16'd0)) begin n_err++; $display("FAIL good_cnt: got %0d want %0d", good_cnt, STATS ? exp_good : 0); end
   endtask

   task automatic test_bad_crc();
      frm[13] = frm[13] ^ 8'h04;
      send_bytes(0, 64, 1'b1, 1'b1, 4, 1'b0);
      idle();
      n_cmp++; if (done !== 1'b1 || crc_ok !== 1'b0) begin n_err++; $display("FAIL bad_crc: got done=%b ok=%b want 1/0", done, crc_ok); end
      n_cmp++; if (len_err !== 1'b0 || frame_len !== 16'd64) begin n_err++; $display("FAIL bad_len: got err=%b len=%0d want 0/64", len_err, frame_len); end
      exp_bad++;
      idle();
      n_cmp++; if (bad_cnt !== (STATS ? 16'(exp_bad) : 16'd0)) begin n_err++; $display("FAIL bad_cnt: got %0d want %0d", bad_cnt, STATS ? exp_bad : 0); end
      frm[13] = frm[13] ^ 8'h04;
   endtask

   task automatic test_runt_keep();
      for (int i = 0; i < 57; i++) frm[i] = 8'(i * 7 + 3);
      append_fcs(57);
      send_bytes(0, 61, 1'b1, 1'b1, 8, 1'b1);
      idle();
      n_cmp++; if (done !== 1'b1 || frame_len !== 16'd61) begin n_err++; $display("FAIL runt_len: got done=%b len=%0d want 1/61", done, frame_len); end
      n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL runt_len_err: got %b want 1", len_err); end
      n_cmp++; if (crc_ok !== 1'b1 || abort !== 1'b0) begin n_err++; $display("FAIL runt_crc_ok: got ok=%b abort=%b want 1/0", crc_ok, abort); end
      exp_bad++;
   endtask

   task automatic test_abort();
      send_bytes(0, 20, 1'b1, 1'b0, 8, 1'b0);
      build_arp();
      send_bytes(0, 8, 1'b1, 1'b0, 8, 1'b0);
      idle();
      n_cmp++; if (done !== 1'b1 || abort !== 1'b1) begin n_err++; $display("FAIL abort_flag: got done=%b abort=%b want 1/1", done, abort); end
      n_cmp++; if (frame_len !== 16'd20) begin n_err++; $display("FAIL abort_len: got %0d want 20", frame_len); end
      n_cmp++; if (crc_ok !== 1'b0 || len_err !== 1'b0) begin n_err++; $display("FAIL abort_flags: got ok=%b err=%b want 0/0", crc_ok, len_err); end
      exp_bad++;
      send_bytes(8, 56, 1'b0, 1'b1, 8, 1'b0);
      idle();
      n_cmp++; if (done !== 1'b1 || crc_ok !== 1'b1 || abort !== 1'b0) begin n_err++; $display("FAIL abort_next: got done=%b ok=%b abort=%b want 1/1/0", done, crc_ok, abort); end
      n_cmp++; if (frame_len !== 16'd64 || len_err !== 1'b0) begin n_err++; $display("FAIL abort_next_len: got %0d err=%b want 64/0", frame_len, len_err); end
      exp_good++;
   endtask

   task automatic test_len_bounds();
      int lens [3];
      logic errs [3];
      lens[0] = 63;   errs[0] = 1'b1;
      lens[1] = 1518; errs[1] = 1'b0;
      lens[2] = 1519; errs[2] = 1'b1;
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < lens[t] - 4; i++) frm[i] = 8'(i * 13 + t + 1);
         append_fcs(lens[t] - 4);
         send_bytes(0, lens[t], 1'b1, 1'b1, 8, 1'b0);
         idle();
         n_cmp++; if (done !== 1'b1 || frame_len !== 16'(lens[t])) begin n_err++; $display("FAIL bound_len_%0d: got done=%b len=%0d want 1/%0d", lens[t], done, frame_len, lens[t]); end
         n_cmp++; if (len_err !== errs[t]) begin n_err++; $display("FAIL bound_err_%0d: got %b want %b", lens[t], len_err, errs[t]); end
         n_cmp++; if (crc_ok !== 1'b1) begin n_err++; $display("FAIL bound_ok_%0d: got %b want 1", lens[t], crc_ok); end
         if (errs[t]) exp_bad++; else exp_good++;
      end
   endtask

   task automatic test_back_to_back();
      build_arp();
      send_bytes(0, 64, 1'b1, 1'b1, 8, 1'b0);
      send_bytes(0, 8, 1'b1, 1'b0, 8, 1'b0);
      n_cmp++; if (done !== 1'b1 || crc_ok !== 1'b1) begin n_err++; $display("FAIL b2b_first: got done=%b ok=%b want 1/1", done, crc_ok); end
      send_bytes(8, 56, 1'b0, 1'b1, 8, 1'b0);
      idle();
      n_cmp++; if (done !== 1'b1 || crc_ok !== 1'b1 || frame_len !== 16'd64) begin n_err++; $display("FAIL b2b_second: got done=%b ok=%b len=%0d want 1/1/64", done, crc_ok, frame_len); end
      exp_good += 2;
   endtask

   task automatic test_keep_zero();
      send_bytes(0, 64, 1'b1, 1'b0, 8, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 64'hDEADBEEFCAFEF00D, 8'hFE);
      idle();
      n_cmp++; if (done !== 1'b1 || crc_ok !== 1'b1) begin n_err++; $display("FAIL keep0_end: got done=%b ok=%b want 1/1", done, crc_ok); end
      n_cmp++; if (frame_len !== 16'd64) begin n_err++; $display("FAIL keep0_len: got %0d want 64", frame_len); end
      exp_good++;
      idle();
      n_cmp++; if (good_cnt !== (STATS ? 16'(exp_good) : 16'd0) || bad_cnt !== (STATS ? 16'(exp_bad) : 16'd0)) begin
         n_err++; $display("FAIL stats_total: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, STATS ? exp_good : 0, STATS ? exp_bad : 0);
      end
   endtask

   task automatic test_reset_mid();
      send_bytes(0, 30, 1'b1, 1'b0, 8, 1'b0);
      do_reset();
      n_cmp++; if (crc !== 32'hFFFFFFFF || frame_len !== 16'd0) begin n_err++; $display("FAIL midrst_regs: got crc=%h len=%0d want ffffffff/0", crc, frame_len); end
      n_cmp++; if (done !== 1'b0 || good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_out: got done=%b cnt=%0d/%0d want 0/0/0", done, good_cnt, bad_cnt); end
      send_bytes(30, 34, 1'b0, 1'b1, 8, 1'b0);
      idle();
      n_cmp++; if (done !== 1'b0 || crc !== 32'hFFFFFFFF) begin n_err++; $display("FAIL midrst_ignore: got done=%b crc=%h want 0/ffffffff", done, crc); end
      send_bytes(0, 64, 1'b1, 1'b1, 8, 1'b0);
      idle();
      n_cmp++; if (done !== 1'b1 || crc_ok !== 1'b1) begin n_err++; $display("FAIL midrst_recover: got done=%b ok=%b want 1/1", done, crc_ok); end
   endtask

   initial begin
      test_reset();
      test_check_value();
      test_good_frame();
      test_bad_crc();
      test_runt_keep();
      test_abort();
      test_len_bounds();
      test_back_to_back();
      test_keep_zero();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
